// File: rtl/gate_result_arb.sv
// gate_result_arb: per-channel result holding, round-robin grant and overrun flags onto one valid/ready stream
module gate_result_arb #(
  parameter int N_CH   = 5,
  parameter int DATA_W = 32,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [N_CH-1:0]        gate_en_i,
  input  logic [N_CH-1:0]        res_valid_i,
  input  logic [N_CH*DATA_W-1:0] res_data_i,
  input  logic                   clr_ovr_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [CH_W-1:0]        out_ch_o,
  output logic [N_CH-1:0]        ovr_o
);

  logic [DATA_W-1:0] hold [N_CH];
  logic [N_CH-1:0]   pend, pend_nxt, ovr_nxt, cap;
  logic [CH_W-1:0]   rr_last, g;
  logic              slot_free, take;
  int                j;

  assign slot_free = !out_valid_o || out_ready_i;
  assign take      = slot_free && (|pend);
  assign cap       = res_valid_i & gate_en_i;

  // round-robin pick: scan from farthest offset down so the nearest pending channel after rr_last wins
  always_comb begin
    g = '0;
    j = 0;
    for (int i = N_CH; i >= 1; i--) begin
      j = int'(rr_last) + i;
      if (j >= N_CH) j = j - N_CH;
      if (pend[j]) g = CH_W'(j);
    end
  end

  // per-channel next pending/overrun state; a capture on the granted channel is not an overwrite
  always_comb begin
    pend_nxt = '0;
    ovr_nxt  = '0;
    for (int k = 0; k < N_CH; k++) begin
      pend_nxt[k] = gate_en_i[k] && (cap[k] || (pend[k] && !(take && g == CH_W'(k))));
      ovr_nxt[k]  = (cap[k] && pend[k] && !(take && g == CH_W'(k))) || (ovr_o[k] && !clr_ovr_i);
    end
  end

  // state registers: hold buffers, pending/overrun flags and the output slot
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < N_CH; k++) hold[k] <= '0;
      pend        <= '0;
      ovr_o       <= '0;
      rr_last     <= CH_W'(N_CH - 1);
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++)
        if (cap[k]) hold[k] <= res_data_i[k*DATA_W +: DATA_W];
      pend  <= pend_nxt;
      ovr_o <= ovr_nxt;
      if (take) begin
        out_valid_o <= 1'b1;
        out_data_o  <= hold[g];
        out_ch_o    <= g;
        rr_last     <= g;
      end else if (slot_free) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule
